deconv2d_host_ctrl: RTL and testbench
=====================================

Name: deconv2d_host_ctrl

Overview:
Initiator-side sequencer for the deconv2D engine. It holds a locally loaded kernel and input image, and drives the engine's enable, kernel and pixel strobe handshakes in the engine's required order. After the engine's done pulse, it walks the engine's result address space and streams every result word out over a valid/ready interface. It sits between the system loader/consumer and one deconv2D instance.

Parameters:
N, 2, input image side length (N*N pixels)
K, 3, maximum kernel side length
pixel_bits, 8, pixel and kernel-weight width; results are pixel_bits*4 wide

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  launch pulse; ignored unless idle
cfg_stride  in  $clog2(K)  stride, latched on start
cfg_kernel_width  in  $clog2(K)  kernel side kw, latched on start
ld_we  in  1  local memory write strobe
ld_sel  in  1  0 = kernel memory (K*K entries), 1 = pixel memory (N*N entries)
ld_addr  in  $clog2(N*N*K*K)  write address (kernel: compact row-major index 0..kw*kw-1)
ld_data  in  pixel_bits  write data
dc_enable  out  1  engine enable pulse
dc_strobe_kernel  out  1  engine kernel strobe
dc_strobe_pixel  out  1  engine pixel strobe
dc_kernel_weight  out  pixel_bits  weight to engine
dc_pixel  out  pixel_bits  pixel to engine
dc_pixel_number  out  $clog2(N*N)  current pixel index
dc_stride  out  $clog2(K)  latched stride
dc_kernel_width  out  $clog2(K)  latched kw
dc_result_address  out  $clog2(N*K*N*K)  readout address
dc_final_output  in  pixel_bits*4  engine result word
dc_ready  in  1  engine ready
dc_done  in  1  engine done pulse
out_valid  out  1  result stream valid
out_ready  in  1  result stream ready
out_data  out  pixel_bits*4  result word (= dc_final_output)
out_index  out  $clog2(N*K*N*K)  address of out_data
busy  out  1  high from accepted start until the FINISH state is left
finish  out  1  one-cycle pulse after the last result is accepted
cfg_err  out  1  sticky; set when start is rejected, cleared by the next accepted start

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs and counters are 0. Local memories are not cleared. The engine's own reset is not driven by this block.
- ld_we is accepted only in IDLE; writes while busy are dropped. Out-of-range ld_addr writes are dropped.
- IDLE: on start:
  - If cfg_kernel_width is 0 or greater than K: set cfg_err and stay IDLE.
  - Otherwise latch the config, clear cfg_err, and go to LAUNCH.
- LAUNCH: dc_enable=1 for exactly 1 cycle, then go to WAIT_KRDY.
- WAIT_KRDY: wait for dc_ready=1, then go to KERNEL.
- KERNEL:
  - Present kernel word k on dc_kernel_weight with dc_strobe_kernel=1, for k = 0..kw*kw-1 on consecutive cycles (one strobe per cycle).
  - Exactly kw*kw strobes are issued.
  - Then go to GAP.
- GAP: 1 idle cycle (the engine needs it to leave its load phase), then go to WAIT_PRDY.
- WAIT_PRDY:
  - Drive dc_pixel = pixel_mem[p] and dc_pixel_number = p.
  - When dc_ready=1, go to PIXEL.
- PIXEL: dc_strobe_pixel=1 for 1 cycle, then go to ACK.
- ACK: 1 cycle. dc_ready is ignored, because the engine's ready drops one cycle late.
- WAIT_NEXT:
  - dc_pixel_number and dc_pixel stay stable throughout, since the engine decodes addresses from them during accumulation.
  - If p < N*N-1 and dc_ready=1: p++ and go to WAIT_PRDY.
  - If p = N*N-1 and dc_done=1: go to READ.
  - dc_done seen with p < N*N-1 is a protocol error: set cfg_err, go to IDLE.
- READ:
  - dc_result_address = r, out_index = r, out_valid=1.
  - out_data follows dc_final_output combinationally.
  - On out_valid && out_ready: r++. If r was (N*K)^2-1, go to FINISH.
  - With out_ready=0, r holds indefinitely.
- FINISH: finish=1 for 1 cycle, busy drops, go to IDLE.
- start during a run is ignored. Async reset mid-run returns to IDLE immediately. A subsequent start re-enables the engine, which clears its RAM itself.
- dc_strobe_kernel and dc_strobe_pixel are never high in the same cycle. dc_enable is never high outside LAUNCH.

Test Plan:
- N=2,K=3, kw=3, stride=3, kernel all 1, pixels 1,2,3,4, out_ready=1:
  - exactly 9 kernel strobes on consecutive cycles, then 4 pixel strobes with dc_pixel_number 0,1,2,3;
  - 36 results streamed with out_index 0..35; sum of out_data = 90; finish pulses once.
- Same run with out_ready toggling 1-of-3 cycles: out_index/out_data hold while stalled; identical 36-word sequence.
- kw=2, kernel words 1,2,3,4, single pixel memory value 5 (others 0): exactly 4 kernel strobes; sum of results = 50.
- start with cfg_kernel_width=0 → cfg_err=1, dc_enable never asserted, busy=0. A later valid start clears cfg_err.
- ld_we and start while busy → memory contents and run unaffected (repeat run and compare outputs).
- rst low during WAIT_NEXT → all outputs 0 in the same cycle. A new start completes normally with correct sum.

Source files
------------

// File: rtl/deconv2d_host_ctrl.sv
// Host-side sequencer for one deconv2D engine: loads kernel and pixels into the
// engine in protocol order, then streams the engine's result memory over valid/ready.
module deconv2d_host_ctrl #(
  parameter int N          = 2,
  parameter int K          = 3,
  parameter int pixel_bits = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(K)-1:0]            cfg_stride,
  input  logic [$clog2(K)-1:0]            cfg_kernel_width,
  input  logic                            ld_we,
  input  logic                            ld_sel,
  input  logic [$clog2(N*N*K*K)-1:0]      ld_addr,
  input  logic [pixel_bits-1:0]           ld_data,
  output logic                            dc_enable,
  output logic                            dc_strobe_kernel,
  output logic                            dc_strobe_pixel,
  output logic [pixel_bits-1:0]           dc_kernel_weight,
  output logic [pixel_bits-1:0]           dc_pixel,
  output logic [$clog2(N*N)-1:0]          dc_pixel_number,
  output logic [$clog2(K)-1:0]            dc_stride,
  output logic [$clog2(K)-1:0]            dc_kernel_width,
  output logic [$clog2(N*K*N*K)-1:0]      dc_result_address,
  input  logic [pixel_bits*4-1:0]         dc_final_output,
  input  logic                            dc_ready,
  input  logic                            dc_done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [pixel_bits*4-1:0]         out_data,
  output logic [$clog2(N*K*N*K)-1:0]      out_index,
  output logic                            busy,
  output logic                            finish,
  output logic                            cfg_err
);

  localparam int SW  = $clog2(K);
  localparam int SW1 = SW + 1;
  localparam int AW  = $clog2(N*N*K*K);
  localparam int PW  = $clog2(N*N);
  localparam int RW  = $clog2(N*K*N*K);
  localparam int KIW = $clog2(K*K);
  localparam int KCW = $clog2(K*K+1);
  localparam logic [AW-1:0]  KMEM_DEPTH = AW'(K*K);
  localparam logic [AW-1:0]  PMEM_DEPTH = AW'(N*N);
  localparam logic [SW1-1:0] KW_MAX     = SW1'(K);
  localparam logic [PW-1:0]  P_LAST     = PW'(N*N-1);
  localparam logic [RW-1:0]  R_LAST     = RW'(N*K*N*K-1);

  typedef enum logic [3:0] {
    S_IDLE, S_LAUNCH, S_WAIT_KRDY, S_KERNEL, S_GAP, S_WAIT_PRDY,
    S_PIXEL, S_ACK, S_WAIT_NEXT, S_READ, S_FINISH
  } state_t;

  state_t                state_r, state_nx_s;
  logic [KCW-1:0]        k_r, k_nx_s, kk_last_s;
  logic [PW-1:0]         p_r, p_nx_s;
  logic [RW-1:0]         r_r, r_nx_s;
  logic [SW-1:0]         stride_r, kw_r;
  logic                  cfg_err_r, cfg_err_nx_s, latch_s;
  logic                  enable_r, strobe_k_r, strobe_p_r, valid_r, busy_r, finish_r;
  logic [pixel_bits-1:0] weight_r, pixel_r;
  logic [pixel_bits-1:0] kmem_r [K*K];
  logic [pixel_bits-1:0] pmem_r [N*N];

  function automatic logic pixel_phase(input state_t s);
    return (s == S_WAIT_PRDY) || (s == S_PIXEL) || (s == S_ACK) || (s == S_WAIT_NEXT);
  endfunction

  assign kk_last_s = KCW'(kw_r) * KCW'(kw_r) - KCW'(1);

  // Next-state, counter and error decisions.
  always_comb begin
    state_nx_s   = state_r;
    k_nx_s       = k_r;
    p_nx_s       = p_r;
    r_nx_s       = r_r;
    cfg_err_nx_s = cfg_err_r;
    latch_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if ((cfg_kernel_width == {SW{1'b0}}) || ({1'b0, cfg_kernel_width} > KW_MAX)) begin
            cfg_err_nx_s = 1'b1;
          end else begin
            latch_s      = 1'b1;
            cfg_err_nx_s = 1'b0;
            k_nx_s       = {KCW{1'b0}};
            p_nx_s       = {PW{1'b0}};
            r_nx_s       = {RW{1'b0}};
            state_nx_s   = S_LAUNCH;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_LAUNCH:    state_nx_s = S_WAIT_KRDY;
      S_WAIT_KRDY: state_nx_s = dc_ready ? S_KERNEL : S_WAIT_KRDY;
      S_KERNEL: begin
        if (k_r == kk_last_s) begin
          state_nx_s = S_GAP;
        end else begin
          k_nx_s = k_r + KCW'(1);
        end
      end
      S_GAP:       state_nx_s = S_WAIT_PRDY;
      S_WAIT_PRDY: state_nx_s = dc_ready ? S_PIXEL : S_WAIT_PRDY;
      S_PIXEL:     state_nx_s = S_ACK;
      // The engine's ready falls one cycle late, so ACK never looks at it.
      S_ACK:       state_nx_s = S_WAIT_NEXT;
      S_WAIT_NEXT: begin
        if (p_r == P_LAST) begin
          state_nx_s = dc_done ? S_READ : S_WAIT_NEXT;
        end else if (dc_done) begin
          cfg_err_nx_s = 1'b1;
          state_nx_s   = S_IDLE;
        end else if (dc_ready) begin
          p_nx_s     = p_r + PW'(1);
          state_nx_s = S_WAIT_PRDY;
        end else begin
          state_nx_s = S_WAIT_NEXT;
        end
      end
      S_READ: begin
        if (out_ready) begin
          if (r_r == R_LAST) begin
            state_nx_s = S_FINISH;
          end else begin
            r_nx_s = r_r + RW'(1);
          end
        end else begin
          state_nx_s = S_READ;
        end
      end
      S_FINISH:    state_nx_s = S_IDLE;
      default:     state_nx_s = S_IDLE;
    endcase
  end

  // State, counters, config and all registered outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      k_r        <= {KCW{1'b0}};
      p_r        <= {PW{1'b0}};
      r_r        <= {RW{1'b0}};
      stride_r   <= {SW{1'b0}};
      kw_r       <= {SW{1'b0}};
      cfg_err_r  <= 1'b0;
      enable_r   <= 1'b0;
      strobe_k_r <= 1'b0;
      strobe_p_r <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      finish_r   <= 1'b0;
      weight_r   <= {pixel_bits{1'b0}};
      pixel_r    <= {pixel_bits{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      k_r        <= k_nx_s;
      p_r        <= p_nx_s;
      r_r        <= r_nx_s;
      cfg_err_r  <= cfg_err_nx_s;
      if (latch_s) begin
        stride_r <= cfg_stride;
        kw_r     <= cfg_kernel_width;
      end
      enable_r   <= (state_nx_s == S_LAUNCH);
      strobe_k_r <= (state_nx_s == S_KERNEL);
      strobe_p_r <= (state_nx_s == S_PIXEL);
      valid_r    <= (state_nx_s == S_READ);
      busy_r     <= (state_nx_s != S_IDLE);
      finish_r   <= (state_nx_s == S_FINISH);
      weight_r   <= (state_nx_s == S_KERNEL) ? kmem_r[KIW'(k_nx_s)] : {pixel_bits{1'b0}};
      pixel_r    <= pixel_phase(state_nx_s) ? pmem_r[p_nx_s] : {pixel_bits{1'b0}};
    end
  end

  // Loader writes land only while idle; the memories are never cleared.
  always_ff @(posedge clk) begin
    if ((state_r == S_IDLE) && ld_we) begin
      if (!ld_sel && (ld_addr < KMEM_DEPTH)) begin
        kmem_r[KIW'(ld_addr)] <= ld_data;
      end else if (ld_sel && (ld_addr < PMEM_DEPTH)) begin
        pmem_r[PW'(ld_addr)] <= ld_data;
      end
    end
  end

  assign dc_enable         = enable_r;
  assign dc_strobe_kernel  = strobe_k_r;
  assign dc_strobe_pixel   = strobe_p_r;
  assign dc_kernel_weight  = weight_r;
  assign dc_pixel          = pixel_r;
  assign dc_pixel_number   = p_r;
  assign dc_stride         = stride_r;
  assign dc_kernel_width   = kw_r;
  assign dc_result_address = r_r;
  assign out_valid         = valid_r;
  assign out_data          = dc_final_output;
  assign out_index         = r_r;
  assign busy              = busy_r;
  assign finish            = finish_r;
  assign cfg_err           = cfg_err_r;

endmodule

// File: tb/tb_deconv2d_host_ctrl.sv
// Bench for deconv2d_host_ctrl: behavioural deconv2D engine model, reference
// deconvolution computed per output position, and a scoreboard on the result stream.
module tb_deconv2d_host_ctrl;
  localparam int N = 2, K = 3, PB = 8, NK = N*K, NR = NK*NK;

  logic clk = 1'b0, rst, start, ld_we, ld_sel, out_ready;
  logic [1:0]  cfg_stride, cfg_kernel_width;
  logic [5:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        dc_enable, dc_strobe_kernel, dc_strobe_pixel, out_valid, busy, finish, cfg_err;
  logic [7:0]  dc_kernel_weight, dc_pixel;
  logic [1:0]  dc_pixel_number, dc_stride, dc_kernel_width;
  logic [5:0]  dc_result_address, out_index;
  logic [31:0] dc_final_output, out_data;
  logic        eng_ready, eng_done;

  always #5 clk = ~clk;

  deconv2d_host_ctrl #(.N(N), .K(K), .pixel_bits(PB)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_stride(cfg_stride),
    .cfg_kernel_width(cfg_kernel_width), .ld_we(ld_we), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .dc_enable(dc_enable),
    .dc_strobe_kernel(dc_strobe_kernel), .dc_strobe_pixel(dc_strobe_pixel),
    .dc_kernel_weight(dc_kernel_weight), .dc_pixel(dc_pixel),
    .dc_pixel_number(dc_pixel_number), .dc_stride(dc_stride),
    .dc_kernel_width(dc_kernel_width), .dc_result_address(dc_result_address),
    .dc_final_output(dc_final_output), .dc_ready(eng_ready), .dc_done(eng_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .finish(finish), .cfg_err(cfg_err)
  );

  int n_tests = 0, n_fail = 0;
  int km [K*K];
  int pm [N*N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- engine model ----------------
  logic [31:0] ram [NR];
  logic [7:0]  wbuf [K*K];
  int          wcnt, boot, acc_cnt;
  logic        late, acc_ev;
  logic [1:0]  cap_pn, acc_pn;
  logic [7:0]  acc_pix;

  assign dc_final_output = ram[dc_result_address];

  always @(posedge clk) begin
    eng_done <= 1'b0;
    acc_ev   <= 1'b0;
    if (!rst) begin
      eng_ready <= 1'b0; boot <= 0; acc_cnt <= 0; late <= 1'b0;
    end else if (dc_enable) begin
      for (int i = 0; i < NR; i++) ram[i] <= 32'd0;
      wcnt <= 0; eng_ready <= 1'b0; boot <= 2; acc_cnt <= 0; late <= 1'b0;
    end else begin
      if (boot > 0) begin
        boot <= boot - 1;
        if (boot == 1) eng_ready <= 1'b1;
      end
      if (dc_strobe_kernel && wcnt < K*K) begin
        wbuf[wcnt] <= dc_kernel_weight;
        wcnt <= wcnt + 1;
      end
      if (dc_strobe_pixel) begin
        late <= 1'b1; cap_pn <= dc_pixel_number;
      end
      if (late) begin
        late <= 1'b0; eng_ready <= 1'b0; acc_cnt <= $urandom_range(1, 4);
      end else if (acc_cnt > 0) begin
        acc_cnt <= acc_cnt - 1;
        if (acc_cnt == 1) begin
          // accumulate using the address/pixel currently presented by the host
          for (int a = 0; a < int'(dc_kernel_width); a++)
            for (int b = 0; b < int'(dc_kernel_width); b++) begin
              int row, col;
              row = (int'(dc_pixel_number) / N) * int'(dc_stride) + a;
              col = (int'(dc_pixel_number) % N) * int'(dc_stride) + b;
              if (row < NK && col < NK)
                ram[row*NK+col] <= ram[row*NK+col] + dc_pixel * wbuf[a*int'(dc_kernel_width)+b];
            end
          acc_ev <= 1'b1; acc_pn <= dc_pixel_number; acc_pix <= dc_pixel;
          if (cap_pn == 2'(N*N-1)) eng_done <= 1'b1;
          else eng_ready <= 1'b1;
        end
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int idx; logic [31:0] data; } exp_t;
  exp_t exp_q[$];

  task automatic push_expected(input int kw, input int st, output longint esum);
    esum = 0;
    for (int y = 0; y < NK; y++)
      for (int x = 0; x < NK; x++) begin
        exp_t e;
        longint s = 0;
        for (int pn = 0; pn < N*N; pn++) begin
          int a = y - (pn / N) * st;
          int b = x - (pn % N) * st;
          if (a >= 0 && a < kw && b >= 0 && b < kw) s += pm[pn] * km[a*kw+b];
        end
        e.idx = y*NK + x; e.data = 32'(s);
        exp_q.push_back(e);
        esum += s;
      end
  endtask

  int     en_tot = 0, ks_tot = 0, ps_tot = 0, fin_tot = 0, acc_tot = 0, krun = 0, pexp = 0, exp_kw = 0;
  longint sum_tot = 0;
  logic   prev_stall = 1'b0;
  logic [5:0]  prev_idx;
  logic [31:0] prev_data;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0; krun = 0;
      end else begin
        if (dc_enable) begin en_tot++; pexp = 0; end
        if (dc_strobe_kernel && dc_strobe_pixel) check("strobe_overlap", 64'd1, 64'd0);
        if (dc_strobe_kernel) begin
          ks_tot++; krun++;
        end else if (krun > 0) begin
          check("kernel_burst_len", 64'(krun), 64'(exp_kw)); krun = 0;
        end
        if (dc_strobe_pixel) begin
          ps_tot++; check("pixel_number", 64'(dc_pixel_number), 64'(pexp)); pexp++;
        end
        if (acc_ev) begin
          check("pixnum_stable", 64'(acc_pn), 64'(cap_pn));
          check("pixel_value", 64'(acc_pix), 64'(pm[cap_pn]));
        end
        if (finish) fin_tot++;
        if (prev_stall)
          check("stall_hold", {25'd0, out_valid, out_index, out_data}, {25'd0, 1'b1, prev_idx, prev_data});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_index", 64'(out_index), 64'(e.idx));
            check("out_data", 64'(out_data), 64'(e.data));
          end
          acc_tot++; sum_tot += out_data;
        end
        prev_stall = out_valid && !out_ready;
        prev_idx = out_index; prev_data = out_data;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  int rdy_mode = 0, rcyc = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1; rcyc++;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = (rcyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic ld(input bit sel, input int addr, input int data);
    @(posedge clk); #1;
    ld_we = 1'b1; ld_sel = sel; ld_addr = 6'(addr); ld_data = 8'(data);
    @(posedge clk); #1;
    ld_we = 1'b0;
    if (!sel && addr < K*K) km[addr] = data & 255;
    if (sel && addr < N*N) pm[addr] = data & 255;
  endtask

  task automatic pulse_start(input int kw, input int st);
    @(posedge clk); #1;
    start = 1'b1; cfg_kernel_width = 2'(kw); cfg_stride = 2'(st);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {dc_enable, dc_strobe_kernel, dc_strobe_pixel, out_valid, busy, finish, cfg_err,
                 dc_kernel_weight, dc_pixel, dc_pixel_number, dc_stride, dc_kernel_width,
                 dc_result_address, out_index}, 64'd0);
  endtask

  task automatic run(input int kw, input int st, input int mode, input bit meddle, input longint fixed_sum);
    longint esum;
    int k0, p0, f0, e0, a0, t;
    longint s0;
    push_expected(kw, st, esum);
    if (fixed_sum >= 0) check("ref_sum_const", 64'(esum), 64'(fixed_sum));
    k0 = ks_tot; p0 = ps_tot; f0 = fin_tot; e0 = en_tot; a0 = acc_tot; s0 = sum_tot;
    exp_kw = kw*kw; rdy_mode = mode;
    pulse_start(kw, st);
    check("busy_after_start", 64'(busy), 64'd1);
    check("cfg_err_cleared", 64'(cfg_err), 64'd0);
    if (meddle) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        ld_we = 1'b1; ld_sel = 1'(i); ld_addr = 6'(i); ld_data = 8'($urandom_range(100, 255));
        start = 1'b1; cfg_kernel_width = 2'(i % 2); cfg_stride = 2'(i);
      end
      @(posedge clk); #1;
      ld_we = 1'b0; start = 1'b0;
    end
    t = 0;
    while (fin_tot == f0 && t < 5000) begin @(negedge clk); t++; end
    check("finish_seen", 64'(fin_tot != f0), 64'd1);
    repeat (2) @(negedge clk);
    check("finish_count", 64'(fin_tot - f0), 64'd1);
    check("enable_count", 64'(en_tot - e0), 64'd1);
    check("kernel_strobes", 64'(ks_tot - k0), 64'(kw*kw));
    check("pixel_strobes", 64'(ps_tot - p0), 64'(N*N));
    check("results_accepted", 64'(acc_tot - a0), 64'(NR));
    check("result_sum", 64'(sum_tot - s0), 64'(esum));
    check("busy_after_finish", 64'(busy), 64'd0);
    check("cfg_err_after_run", 64'(cfg_err), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int e0, t;
    rst = 1'b0; start = 1'b0; ld_we = 1'b0; ld_sel = 1'b0; ld_addr = 6'd0; ld_data = 8'd0;
    cfg_stride = 2'd0; cfg_kernel_width = 2'd0;
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset_outputs");
    rst = 1'b1;

    // kernel all ones, pixels 1..4, kw=3 stride=3
    for (int i = 0; i < 9; i++) ld(1'b0, i, 1);
    for (int i = 0; i < 4; i++) ld(1'b1, i, i + 1);
    run(3, 3, 0, 1'b0, 90);
    run(3, 3, 1, 1'b0, 90);

    // kw=2, weights 1..4, single pixel 5; out-of-range writes must be dropped
    for (int i = 0; i < 4; i++) ld(1'b0, i, i + 1);
    ld(1'b1, 0, 5); ld(1'b1, 1, 0); ld(1'b1, 2, 0); ld(1'b1, 3, 0);
    ld(1'b1, 4, 77); ld(1'b0, 16, 77); ld(1'b1, 36, 77);
    run(2, 2, 2, 1'b0, 50);

    // rejected start: kw=0
    e0 = en_tot;
    pulse_start(0, 1);
    repeat (5) @(negedge clk);
    check("cfg_err_set", 64'(cfg_err), 64'd1);
    check("busy_rejected", 64'(busy), 64'd0);
    check("no_enable_rejected", 64'(en_tot - e0), 64'd0);
    run(2, 1, 0, 1'b0, -1);

    // loader writes and start while busy must not disturb the run
    run(3, 2, 2, 1'b1, -1);
    run(3, 2, 0, 1'b0, -1);

    // randomized configurations and contents
    for (int r = 0; r < 4; r++) begin
      int kw = $urandom_range(1, 3);
      for (int i = 0; i < kw*kw; i++) ld(1'b0, i, $urandom_range(0, 255));
      for (int i = 0; i < N*N; i++) ld(1'b1, i, $urandom_range(0, 255));
      run(kw, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, -1);
    end

    // asynchronous reset in the middle of a run
    exp_kw = 9;
    pulse_start(3, 1);
    t = 0;
    while (!(dc_strobe_pixel && dc_pixel_number == 2'd1) && t < 2000) begin @(negedge clk); t++; end
    check("reach_pixel1", 64'(t < 2000), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_outputs_zero("midrun_reset_outputs");
    @(posedge clk); #1;
    rst = 1'b1;
    run(3, 1, 2, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end
endmodule
